// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU memory-port arbiter: FSM states, requester
// port IDs and the legal range of the memory read latency.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;

  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the port not most recently
// granted wins; the last-grant pointer resets so that the data port wins first.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  req_if,
  input  logic  req_d,
  input  logic  take,
  output logic  valid,
  output port_e winner
);

  port_e last;

  always_comb begin
    valid  = req_if | req_d;
    winner = PORT_D;
    if (req_if && req_d) begin
      winner = (last == PORT_D) ? PORT_IF : PORT_D;
    end else if (req_if) begin
      winner = PORT_IF;
    end
  end

  // Pointer moves only when the owner of the arbiter actually accepts the winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= PORT_IF;
    end else if (take && valid) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory between the fetch and data ports of the CPU,
// one transaction at a time, sequencing the fixed memory read latency.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LAT);

  arb_state_e           state, state_nx;
  port_e                owner;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 arb_valid, arb_take;
  port_e                arb_winner;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .req_if (if_req),
    .req_d  (d_req),
    .take   (arb_take),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // DONE arbitrates exactly like IDLE so back-to-back transactions leave no gap.
  always_comb begin
    state_nx = state;
    arb_take = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arb_valid) begin
          arb_take = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE:   state_nx = mem_we ? DONE : WAIT;
      WAIT:    if (cnt == LAT_LAST) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en  = (state == ISSUE);
  assign if_gnt  = mem_en && (owner == PORT_IF);
  assign d_gnt   = mem_en && (owner == PORT_D);
  assign if_done = (state == DONE) && (owner == PORT_IF);
  assign d_done  = (state == DONE) && (owner == PORT_D);

  // Request fields are latched at arbitration and then held until the next win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= PORT_IF;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (arb_take) begin
        owner <= arb_winner;
        if (arb_winner == PORT_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we   <= 1'b0;
          mem_addr <= if_addr;
        end
      end
      if (state == ISSUE) begin
        cnt <= LAT_CNT_W'(1);
      end else if (state == WAIT && cnt != LAT_LAST) begin
        cnt <= cnt + LAT_CNT_W'(1);
      end
      if (state == WAIT && cnt == LAT_LAST) begin
        if (owner == PORT_IF) begin
          if_rdata <= mem_rdata;
        end else begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter: a transaction-level model
// predicts grant order, pulse cycles and returned data for a LAT=3 and a LAT=15 DUT.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int XLAT = 15;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic clk, reset_n;
  logic if_req, if_gnt, if_done, d_req, d_we, d_gnt, d_done, mem_en, mem_we;
  logic [9:0]  if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  logic x_if_req, x_if_gnt, x_if_done, x_d_req, x_d_we, x_d_gnt, x_d_done, x_mem_en, x_mem_we;
  logic [9:0]  x_if_addr, x_d_addr, x_mem_addr;
  logic [31:0] x_if_rdata, x_d_wdata, x_d_rdata, x_mem_wdata, x_mem_rdata;

  int tests_run, tests_failed;
  int last_port;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic [31:0] ref_mem [1024];

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(XLAT)) u_dut15 (
    .clk(clk), .reset_n(reset_n),
    .if_req(x_if_req), .if_addr(x_if_addr), .if_gnt(x_if_gnt), .if_done(x_if_done),
    .if_rdata(x_if_rdata),
    .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
    .d_gnt(x_d_gnt), .d_done(x_d_done), .d_rdata(x_d_rdata),
    .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_rdata(x_mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [9:0] a);
    if (a == 10'd5) return 32'h0000_AF01;
    return ({22'd0, a} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: writes land on the strobe edge, reads appear LAT cycles after the strobe.
  logic [31:0] mem [1024];
  bit          written [1024];
  logic [31:0] rpipe [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rpipe[0] <= (mem_en && !mem_we) ? (written[mem_addr] ? mem[mem_addr] : init_word(mem_addr)) : POISON;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  logic [31:0] x_mem [1024];
  bit          x_written [1024];
  logic [31:0] x_rpipe [XLAT];
  always @(posedge clk) begin
    if (x_mem_en && x_mem_we) begin
      x_mem[x_mem_addr]     <= x_mem_wdata;
      x_written[x_mem_addr] <= 1'b1;
    end
    x_rpipe[0] <= (x_mem_en && !x_mem_we) ?
                  (x_written[x_mem_addr] ? x_mem[x_mem_addr] : init_word(x_mem_addr)) : POISON;
    for (int i = 1; i < XLAT; i++) x_rpipe[i] <= x_rpipe[i-1];
  end
  assign x_mem_rdata = x_rpipe[XLAT-1];

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({if_gnt, if_done, d_gnt, d_done, mem_en, mem_we} !== 6'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got strobes=%b addr=%0h wdata=%0h exp all 0",
               {if_gnt, if_done, d_gnt, d_done, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tests_run++;
    if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rdata got if=%0h d=%0h exp 0", if_rdata, d_rdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({if_gnt, d_gnt, mem_en, if_done, d_done} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset got=%b exp=00000", {if_gnt, d_gnt, mem_en, if_done, d_done});
    end
  endtask

  task automatic test_back_to_back();
    localparam int K = 8;
    int pt [K], g [K], dn [K];
    logic we [K];
    logic [9:0] ad [K];
    logic [31:0] wd [K], rd_exp [K];
    logic e_ig, e_dg, e_id, e_dd, e_en;
    int first, iss, i_if, i_d;
    first = (last_port == 1) ? 0 : 1;
    for (int n = 0; n < K; n++) begin
      pt[n] = first ^ (n & 1);
      ad[n] = 10'($urandom_range(0, 7));
      we[n] = (pt[n] == 1) && ($urandom_range(0, 1) == 1);
      wd[n] = $urandom;
      g[n]  = (n == 0) ? 1 : dn[n-1] + 1;
      dn[n] = g[n] + 1 + (we[n] ? 0 : LAT);
      if (we[n]) ref_mem[ad[n]] = wd[n];
      else rd_exp[n] = ref_mem[ad[n]];
    end
    last_port = pt[K-1];
    i_if = (pt[0] == 0) ? 0 : 1;
    i_d  = 1 - i_if;
    if_req = 1'b1; if_addr = ad[i_if];
    d_req = 1'b1; d_addr = ad[i_d]; d_we = we[i_d]; d_wdata = wd[i_d];
    for (int k = 1; k <= dn[K-1] + 1; k++) begin
      @(negedge clk);
      {e_ig, e_dg, e_id, e_dd, e_en} = 5'b0;
      iss = -1;
      for (int n = 0; n < K; n++) begin
        if (k == g[n]) begin
          iss = n; e_en = 1'b1;
          if (pt[n] == 0) e_ig = 1'b1; else e_dg = 1'b1;
        end
        if (k == dn[n]) begin
          if (pt[n] == 0) begin e_id = 1'b1; exp_if_rdata = rd_exp[n]; end
          else begin e_dd = 1'b1; if (!we[n]) exp_d_rdata = rd_exp[n]; end
        end
      end
      tests_run++;
      if ({if_gnt, d_gnt, if_done, d_done, mem_en} !== {e_ig, e_dg, e_id, e_dd, e_en}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_strobes cycle %0d got=%b exp=%b", k,
                 {if_gnt, d_gnt, if_done, d_done, mem_en}, {e_ig, e_dg, e_id, e_dd, e_en});
      end
      tests_run++;
      if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rdata cycle %0d got if=%0h d=%0h exp if=%0h d=%0h",
                 k, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
      end
      if (iss >= 0) begin
        tests_run++;
        if (mem_addr !== ad[iss] || mem_we !== we[iss] || (we[iss] && mem_wdata !== wd[iss])) begin
          tests_failed++;
          $display("[TB] FAIL b2b_issue txn %0d got addr=%0h we=%b wdata=%0h exp addr=%0h we=%b wdata=%0h",
                   iss, mem_addr, mem_we, mem_wdata, ad[iss], we[iss], wd[iss]);
        end
        if (pt[iss] == 0) begin
          if (iss + 2 < K) if_addr = ad[iss+2]; else if_req = 1'b0;
        end else begin
          if (iss + 2 < K) begin d_addr = ad[iss+2]; d_we = we[iss+2]; d_wdata = wd[iss+2]; end
          else d_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_transactions(input int n_iter);
    logic use_if, use_d, dwe, is_rd, e_ig, e_dg, e_id, e_dd, e_en, exp_we, held_we;
    logic [9:0] ia, da, exp_addr, held_addr;
    logic [31:0] dw;
    logic [31:0] rd_exp [2];
    int pt [2], g [2], dn [2];
    int cnt_t, iss;
    held_addr = mem_addr;
    held_we = mem_we;
    for (int it = 0; it < n_iter; it++) begin
      case (it)
        0: begin use_if = 1; use_d = 0; dwe = 0; ia = 10'd5; da = 10'd0; dw = 32'd0; end
        1: begin use_if = 0; use_d = 1; dwe = 1; ia = 10'd0; da = 10'd1020; dw = 32'h008D_0001; end
        2: begin use_if = 0; use_d = 1; dwe = 0; ia = 10'd0; da = 10'd1020; dw = 32'd0; end
        3: begin use_if = 1; use_d = 1; dwe = 1; ia = 10'd1020; da = 10'd1020; dw = 32'h1234_5678; end
        default: begin
          use_if = 1'($urandom_range(0, 1));
          use_d  = 1'($urandom_range(0, 1));
          if (!use_if && !use_d) use_if = 1'b1;
          dwe = 1'($urandom_range(0, 1));
          ia  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
          da  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
          dw  = $urandom;
        end
      endcase
      if (use_if && use_d) begin
        pt[0] = (last_port == 1) ? 0 : 1; pt[1] = 1 - pt[0]; cnt_t = 2;
      end else begin
        pt[0] = use_d ? 1 : 0; pt[1] = 0; cnt_t = 1;
      end
      for (int t = 0; t < cnt_t; t++) begin
        g[t]  = (t == 0) ? 1 : dn[t-1] + 1;
        is_rd = (pt[t] == 0) || !dwe;
        dn[t] = g[t] + 1 + (is_rd ? LAT : 0);
        if (!is_rd) ref_mem[da] = dw;
        else rd_exp[t] = ref_mem[(pt[t] == 0) ? ia : da];
      end
      last_port = pt[cnt_t-1];
      if_req = use_if; if_addr = ia; d_req = use_d; d_we = dwe; d_addr = da; d_wdata = dw;
      for (int k = 1; k <= dn[cnt_t-1] + 1; k++) begin
        @(negedge clk);
        {e_ig, e_dg, e_id, e_dd, e_en} = 5'b0;
        iss = -1;
        for (int t = 0; t < cnt_t; t++) begin
          if (k == g[t]) begin
            iss = t; e_en = 1'b1;
            if (pt[t] == 0) e_ig = 1'b1; else e_dg = 1'b1;
          end
          if (k == dn[t]) begin
            if (pt[t] == 0) begin e_id = 1'b1; exp_if_rdata = rd_exp[t]; end
            else begin e_dd = 1'b1; if (!dwe) exp_d_rdata = rd_exp[t]; end
          end
        end
        tests_run++;
        if ({if_gnt, d_gnt, if_done, d_done, mem_en} !== {e_ig, e_dg, e_id, e_dd, e_en}) begin
          tests_failed++;
          $display("[TB] FAIL txn_strobes it %0d cycle %0d got=%b exp=%b", it, k,
                   {if_gnt, d_gnt, if_done, d_done, mem_en}, {e_ig, e_dg, e_id, e_dd, e_en});
        end
        tests_run++;
        if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
          tests_failed++;
          $display("[TB] FAIL txn_rdata it %0d cycle %0d got if=%0h d=%0h exp if=%0h d=%0h",
                   it, k, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
        end
        if (iss >= 0) begin
          exp_we   = (pt[iss] == 1) && dwe;
          exp_addr = (pt[iss] == 0) ? ia : da;
          held_addr = exp_addr;
          held_we   = exp_we;
          // Requester is free to change its inputs once granted.
          if (pt[iss] == 0) begin
            if_req = 1'b0; if_addr = 10'($urandom);
          end else begin
            d_req = 1'b0; d_addr = 10'($urandom); d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
          end
        end
        tests_run++;
        if (mem_addr !== held_addr || mem_we !== held_we || (iss >= 0 && held_we && mem_wdata !== dw)) begin
          tests_failed++;
          $display("[TB] FAIL txn_memif it %0d cycle %0d got addr=%0h we=%b wdata=%0h exp addr=%0h we=%b wdata=%0h",
                   it, k, mem_addr, mem_we, mem_wdata, held_addr, held_we, dw);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [9:0] a;
    logic [31:0] w;
    a = 10'($urandom_range(0, 7)); w = $urandom;
    ref_mem[a] = w;
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      tests_run++;
      if (if_done !== 1'b0 || if_gnt !== 1'b0 || if_rdata !== exp_if_rdata) begin
        tests_failed++;
        $display("[TB] FAIL hold_if cycle %0d got done=%b gnt=%b rdata=%0h exp 0 0 %0h",
                 k, if_done, if_gnt, if_rdata, exp_if_rdata);
      end
      tests_run++;
      if (d_gnt !== ((k % 2) == 1 && k <= 11) || d_done !== ((k % 2) == 0 && k <= 12)) begin
        tests_failed++;
        $display("[TB] FAIL hold_d cycle %0d got gnt=%b done=%b", k, d_gnt, d_done);
      end
      if ((k % 2) == 1 && k < 11) begin
        a = 10'($urandom_range(0, 7)); w = $urandom;
        ref_mem[a] = w;
        d_addr = a; d_wdata = w;
      end else if (k == 11) begin
        d_req = 1'b0;
      end
    end
    last_port = 1;
  endtask

  task automatic test_reset_wait();
    logic [9:0] a;
    a = 10'($urandom_range(8, 1000));
    if_req = 1'b1; if_addr = a; d_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    if_req = 1'b0;
    #1;
    tests_run++;
    if ({if_gnt, if_done, d_gnt, d_done, mem_en, mem_we} !== 6'b0 || mem_addr !== 10'd0 ||
        mem_wdata !== 32'd0 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got strobes=%b addr=%0h rdata if=%0h d=%0h exp all 0",
               {if_gnt, if_done, d_gnt, d_done, mem_en, mem_we}, mem_addr, if_rdata, d_rdata);
    end
    last_port = 0; exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      tests_run++;
      if ({if_gnt, if_done, d_gnt, d_done, mem_en} !== 5'b0 || if_rdata !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_quiet cycle %0d got strobes=%b if_rdata=%0h exp 0",
                 k, {if_gnt, if_done, d_gnt, d_done, mem_en}, if_rdata);
      end
    end
    a = 10'($urandom_range(0, 7));
    if_req = 1'b1; if_addr = a;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (k == 1) if_req = 1'b0;
      if (k == LAT + 2) exp_if_rdata = ref_mem[a];
      tests_run++;
      if (if_gnt !== (k == 1) || mem_en !== (k == 1) || if_done !== (k == LAT + 2) || if_rdata !== exp_if_rdata) begin
        tests_failed++;
        $display("[TB] FAIL clean_restart cycle %0d got gnt=%b en=%b done=%b rdata=%0h exp rdata=%0h",
                 k, if_gnt, mem_en, if_done, if_rdata, exp_if_rdata);
      end
    end
    last_port = 0;
  endtask

  task automatic test_lat15();
    logic [9:0] a;
    logic [31:0] e;
    a = 10'($urandom);
    e = 32'd0;
    x_if_req = 1'b1; x_if_addr = a;
    for (int k = 1; k <= XLAT + 4; k++) begin
      @(negedge clk);
      if (k == 1) x_if_req = 1'b0;
      if (k == XLAT + 2) e = init_word(a);
      tests_run++;
      if (x_if_gnt !== (k == 1) || x_mem_en !== (k == 1) || x_if_done !== (k == XLAT + 2) ||
          x_if_rdata !== e || {x_d_gnt, x_d_done} !== 2'b00 || x_d_rdata !== 32'd0) begin
        tests_failed++;
        $display("[TB] FAIL lat15 cycle %0d got gnt=%b en=%b done=%b rdata=%0h exp done=%b rdata=%0h",
                 k, x_if_gnt, x_mem_en, x_if_done, x_if_rdata, (k == XLAT + 2), e);
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    last_port = 0;
    exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = 10'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 10'd0; d_wdata = 32'd0;
    x_if_req = 1'b0; x_if_addr = 10'd0; x_d_req = 1'b0; x_d_we = 1'b0; x_d_addr = 10'd0; x_d_wdata = 32'd0;
    test_reset();
    test_back_to_back();
    test_transactions(60);
    test_hold();
    test_back_to_back();
    test_reset_wait();
    test_lat15();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
